// File: rtl/dma_channel_arbiter_if.sv
// Bus bundle between the DMA channel arbiter, its four requesting channels and the DMA engine.
// The arbiter uses the master view; requesters and engine together form the slave side.
interface dma_channel_arbiter_if;
    logic [3:0]  req;
    logic [39:0] desc_origin;
    logic [39:0] desc_dest;
    logic [19:0] desc_qty;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [3:0]  err;
    logic        busy;
    logic [9:0]  OriginAddress;
    logic [9:0]  DestinationAddress;
    logic [4:0]  BytesQuantity;
    logic        dma_load;
    logic        dma_start;
    logic        dma_ack;
    logic        dma_int;

    modport master (
        input  req, desc_origin, desc_dest, desc_qty, dma_ack, dma_int,
        output grant, done, err, busy, OriginAddress, DestinationAddress, BytesQuantity,
               dma_load, dma_start
    );

    modport slave (
        output req, desc_origin, desc_dest, desc_qty, dma_ack, dma_int,
        input  grant, done, err, busy, OriginAddress, DestinationAddress, BytesQuantity,
               dma_load, dma_start
    );
endinterface

// File: rtl/dma_channel_arbiter.sv
// Round-robin arbiter handing one DMA engine to four channels, with descriptor latching
// and a LOAD/BUSY watchdog that aborts a stalled transfer.
//
//   state | meaning
//   IDLE  | no owner; arbitrate when any req is high (skipped in the cycle err pulses)
//   LOAD  | dma_load high, waiting for dma_ack
//   START | one-cycle dma_start strobe
//   BUSY  | transfer running, waiting for dma_int
//   DONE  | one-cycle done pulse to the owner, grant still held
module dma_channel_arbiter #(
    parameter int N_CH    = 4,
    parameter int TIMEOUT = 1024
) (
    input logic                  clk,
    input logic                  rst,
    dma_channel_arbiter_if.master bus
);
    localparam int CHW = $clog2(N_CH);
    localparam int CW  = $clog2(TIMEOUT);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] BUSY  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]      state;
    logic [CHW-1:0]  ptr;
    logic [CHW-1:0]  ch;
    logic [N_CH-1:0] grant;
    logic [N_CH-1:0] err;
    logic [CW-1:0]   tmo_cnt;
    logic [9:0]      origin;
    logic [9:0]      dest;
    logic [4:0]      qty;

    logic [CHW-1:0]  idx;
    logic [CHW-1:0]  pick;
    logic            pick_vld;
    logic [N_CH-1:0] pick_oh;
    logic [4:0]      pick_qty;
    logic            tmo_hit;

    // Walk downward so the channel closest above ptr is the one left standing.
    always_comb begin
        idx      = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = ptr + CHW'(i);
            if (bus.req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        pick_oh       = '0;
        pick_oh[pick] = 1'b1;
    end

    assign pick_qty = bus.desc_qty[int'(pick) * 5 +: 5];
    assign tmo_hit  = (tmo_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            ch      <= '0;
            grant   <= '0;
            err     <= '0;
            tmo_cnt <= '0;
            origin  <= '0;
            dest    <= '0;
            qty     <= '0;
        end else begin
            err <= '0;
            case (state)
                IDLE: begin
                    if (|err) begin
                        grant <= '0;
                    end else if (pick_vld) begin
                        grant  <= pick_oh;
                        ch     <= pick;
                        origin <= bus.desc_origin[int'(pick) * 10 +: 10];
                        dest   <= bus.desc_dest[int'(pick) * 10 +: 10];
                        qty    <= pick_qty;
                        if (pick_qty != 5'd0) begin
                            state   <= LOAD;
                            tmo_cnt <= '0;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                LOAD: begin
                    if (tmo_hit) begin
                        state <= IDLE;
                        err   <= grant;
                        ptr   <= ch + CHW'(1);
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                        if (bus.dma_ack) state <= START;
                    end
                end
                START: state <= BUSY;
                BUSY: begin
                    // Completion beats a coincident watchdog expiry.
                    if (bus.dma_int) begin
                        state <= DONE;
                    end else if (tmo_hit) begin
                        state <= IDLE;
                        err   <= grant;
                        ptr   <= ch + CHW'(1);
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    grant <= '0;
                    ptr   <= ch + CHW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant              = grant;
    assign bus.done               = (state == DONE) ? grant : '0;
    assign bus.err                = err;
    assign bus.busy               = (state != IDLE);
    assign bus.dma_load           = (state == LOAD);
    assign bus.dma_start          = (state == START);
    assign bus.OriginAddress      = origin;
    assign bus.DestinationAddress = dest;
    assign bus.BytesQuantity      = qty;
endmodule

// File: doc/dma_channel_arbiter.md
DMA_CHANNEL_ARBITER -- requirements
Module: dma_channel_arbiter

Interface
REQ-001 Parameter: N_CH, 4, number of requesting channels; fixed at 4 for this revision.
REQ-002 Parameter: TIMEOUT, 1024, maximum cycles a grant may spend in LOAD plus BUSY before it is aborted.
REQ-003 Port: clk  in  1  single clock; all logic is on its rising edge.
REQ-004 Port: rst  in  1  reset, synchronous and active-high.
REQ-005 Port: req  in  4  per-channel transfer request, level, held by requester until done or err.
REQ-006 Port: desc_origin  in  40  packed origin addresses; channel i is at [10i+9:10i].
REQ-007 Port: desc_dest  in  40  packed destination addresses; same packing as desc_origin.
REQ-008 Port: desc_qty  in  20  packed byte counts; channel i is at [5i+4:5i].
REQ-009 Port: grant  out  4  one-hot owner of the DMA engine; all zero when idle.
REQ-010 Port: done  out  4  one-cycle completion pulse to the granted channel.
REQ-011 Port: err  out  4  one-cycle timeout-abort pulse to the granted channel.
REQ-012 Port: busy  out  1  high in every state except IDLE.
REQ-013 Port: OriginAddress  out  10  latched origin address driven to the DMA engine.
REQ-014 Port: DestinationAddress  out  10  latched destination address driven to the DMA engine.
REQ-015 Port: BytesQuantity  out  5  latched byte count driven to the DMA engine.
REQ-016 Port: dma_load  out  1  load strobe to the DMA engine.
REQ-017 Port: dma_start  out  1  start strobe to the DMA engine.
REQ-018 Port: dma_ack  in  1  DMA engine acknowledge that the load was accepted.
REQ-019 Port: dma_int  in  1  DMA engine transfer-complete interrupt.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, LOAD, START, BUSY and DONE.
REQ-021 In IDLE with any req bit high, the FSM SHALL select a channel round-robin, searching upward from pointer ptr with wrap from 3 to 0.
REQ-022 On selection, the block SHALL register grant, OriginAddress, DestinationAddress and BytesQuantity from the selected channel's descriptor, one cycle after req is sampled.
REQ-023 Descriptor outputs SHALL remain stable until the FSM returns to IDLE; later descriptor input changes SHALL be ignored.
REQ-024 On selection with a nonzero count, the FSM SHALL enter LOAD and drive dma_load=1.
REQ-025 On selection with a zero count, the FSM SHALL go directly to DONE without asserting dma_load or dma_start.
REQ-026 In LOAD, dma_load SHALL stay high until dma_ack=1 is sampled; the FSM SHALL then enter START.
REQ-027 START SHALL last exactly one cycle with dma_load=0 and dma_start=1, then the FSM SHALL enter BUSY.
REQ-028 In BUSY, sampling dma_int=1 SHALL move the FSM to DONE.
REQ-029 If dma_int=1 is sampled outside BUSY, the block SHALL ignore it.
REQ-030 DONE SHALL last one cycle, with done[ch]=1 and grant still asserted.
REQ-031 On the cycle after DONE: grant=0, ptr=(ch+1) mod 4, and the FSM SHALL be in IDLE.
REQ-032 A timeout counter SHALL clear on entry to LOAD and increment in every LOAD and BUSY cycle.
REQ-033 When the timeout counter reaches TIMEOUT-1, the FSM SHALL go to IDLE, pulse err[ch] for one cycle, deassert dma_load and dma_start, clear grant on the following cycle, and advance ptr exactly as after DONE.
REQ-034 If dma_int and the timeout occur in the same cycle, the block SHALL treat it as a completion: done is asserted and err is not.
REQ-035 A requester dropping req mid-grant SHALL NOT abort the transfer; done or err is still issued.
REQ-036 A req that rises in the same cycle as a DONE SHALL be arbitrated in the following IDLE cycle; the minimum gap between grants is one IDLE cycle.
REQ-037 grant, done and err SHALL each be zero or one-hot, and done and err SHALL never both be asserted in the same cycle.

Reset
REQ-038 When rst=1 at a clock edge, state SHALL be IDLE and ptr=0.
REQ-039 When rst=1 at a clock edge, the timeout counter SHALL be 0.
REQ-040 When rst=1 at a clock edge, grant, done, err, busy, dma_load, dma_start, OriginAddress, DestinationAddress and BytesQuantity SHALL all be 0.
REQ-041 Reset asserted mid-transfer SHALL abandon the transfer with no done or err pulse.

Verification
REQ-042 Single request: req=0001, desc0=(0x010,0x200,5), dma_ack one cycle after dma_load -> grant=0001, one dma_start pulse; dma_int -> done=0001 for one cycle, then idle with ptr=1.
REQ-043 Fairness: req=1111 held for 8 transfers -> grant order 0,1,2,3,0,1,2,3.
REQ-044 Zero count: req=0100, qty2=0 -> done=0100 two cycles after req; dma_load and dma_start never assert.
REQ-045 Timeout: dma_int held low, TIMEOUT=16 -> err[ch] pulse 16 cycles after LOAD entry, done stays low, next channel is granted.
REQ-046 Collision: dma_int and the timeout in the same cycle -> done pulses, err stays 0.
REQ-047 Reset in BUSY -> all outputs 0 on the next edge, no done or err; a pending req is re-granted starting from channel 0.
